// File: rtl/l1_arb_pkg.sv
// l1_arb_pkg: shared types and widths for the L1 request arbiter
package l1_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } cache_req_t;
endpackage

// File: rtl/l1_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, searching upward from rr_ptr with wrap
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [2*N-1:0] rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  // rotating the doubled vector puts rr_ptr at bit 0, so the lowest set bit is the winner's distance
  always_comb begin
    rot = {req, req} >> rr_ptr;
    off = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = IW'(k);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    gnt_idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
    gnt = (|req) ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/l1_req_arbiter.sv
// l1_req_arbiter: round-robin share of the L1 CPU-side port, one transaction in flight, with watchdog abort
module l1_req_arbiter
  import l1_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         rq_valid,
  output logic [NUM_REQ-1:0]         rq_ready,
  input  logic [NUM_REQ-1:0]         rq_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  rq_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  rq_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]  rq_wstrb,
  output logic [NUM_REQ-1:0]         rs_valid,
  output logic [DATA_W-1:0]          rs_rdata,
  output logic                       rs_err,
  output logic                       cache_req_valid,
  output logic                       cache_req_we,
  output logic [ADDR_W-1:0]          cache_req_addr,
  output logic [DATA_W-1:0]          cache_req_wdata,
  output logic [STRB_W-1:0]          cache_req_wstrb,
  input  logic                       cache_resp_valid,
  input  logic [DATA_W-1:0]          cache_resp_rdata,
  input  logic                       cache_resp_stall,
  output logic [31:0]                timeout_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  arb_state_e         state;
  logic [IW-1:0]      rr_ptr, win_idx, gnt_q;
  logic [NUM_REQ-1:0] win;
  logic [TW-1:0]      to_cnt;
  cache_req_t         req_q, req_d;
  logic               accept, resp_hit, to_hit;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req     (rq_valid),
    .rr_ptr  (rr_ptr),
    .gnt     (win),
    .gnt_idx (win_idx)
  );
  // rst_n gating keeps ready low while reset is held, even though state already reads IDLE
  assign rq_ready = (rst_n && state == IDLE && !cache_resp_stall) ? win : '0;
  assign accept   = |(rq_valid & rq_ready);
  assign resp_hit = (state == BUSY) && cache_resp_valid;
  assign to_hit   = (TIMEOUT_CYCLES != 0) && (state == BUSY) && !cache_resp_valid && (to_cnt == TO_LAST);
  always_comb begin
    req_d = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_idx == IW'(i))
        req_d = '{we: rq_we[i], addr: rq_addr[ADDR_W*i +: ADDR_W],
                  wdata: rq_wdata[DATA_W*i +: DATA_W], wstrb: rq_wstrb[STRB_W*i +: STRB_W]};
  end
  assign cache_req_valid = (state == BUSY);
  assign cache_req_we    = req_q.we;
  assign cache_req_addr  = req_q.addr;
  assign cache_req_wdata = req_q.wdata;
  assign cache_req_wstrb = req_q.wstrb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      gnt_q         <= '0;
      req_q         <= '0;
      to_cnt        <= '0;
      rs_valid      <= '0;
      rs_rdata      <= '0;
      rs_err        <= 1'b0;
      timeout_count <= '0;
    end else begin
      rs_valid <= (resp_hit || to_hit) ? (NUM_REQ'(1) << gnt_q) : '0;
      if (state == IDLE) begin
        if (accept) begin
          state  <= BUSY;
          gnt_q  <= win_idx;
          req_q  <= req_d;
          to_cnt <= '0;
          rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end else begin
        to_cnt <= to_cnt + 1'b1;
        if (resp_hit) begin
          state    <= IDLE;
          rs_rdata <= cache_resp_rdata;
          rs_err   <= 1'b0;
        end else if (to_hit) begin
          state    <= IDLE;
          rs_rdata <= '0;
          rs_err   <= 1'b1;
          if (timeout_count != '1) timeout_count <= timeout_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_l1_req_arbiter.sv
// tb_l1_req_arbiter: directed checks of grant order, latency, stall, timeout and reset behaviour
module tb_l1_req_arbiter;
  localparam int N = 2;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  rq_valid = '0, rq_ready, rq_we = '0, rs_valid;
  logic [N*32-1:0] rq_addr = {32'h200, 32'h100}, rq_wdata = {32'h22, 32'h11};
  logic [N*4-1:0]  rq_wstrb = 8'hFF;
  logic [31:0]   rs_rdata, cache_req_addr, cache_req_wdata, cache_resp_rdata = '0, timeout_count;
  logic          rs_err, cache_req_valid, cache_req_we, cache_resp_valid = 1'b0, cache_resp_stall = 1'b0;
  logic [3:0]    cache_req_wstrb;
  int            n_cmp = 0, n_bad = 0;

  l1_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_we(rq_we),
    .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb), .rs_valid(rs_valid),
    .rs_rdata(rs_rdata), .rs_err(rs_err), .cache_req_valid(cache_req_valid),
    .cache_req_we(cache_req_we), .cache_req_addr(cache_req_addr), .cache_req_wdata(cache_req_wdata),
    .cache_req_wstrb(cache_req_wstrb), .cache_resp_valid(cache_resp_valid),
    .cache_resp_rdata(cache_resp_rdata), .cache_resp_stall(cache_resp_stall),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state, with requests pending during reset
    rq_valid = 2'b11;
    #2;
    chk("reset_rq_ready", rq_ready, 0);
    chk("reset_cache_req_valid", cache_req_valid, 0);
    chk("reset_cache_req_addr", cache_req_addr, 0);
    chk("reset_rs_valid", rs_valid, 0);
    chk("reset_rs_rdata", rs_rdata, 0);
    chk("reset_rs_err", rs_err, 0);
    chk("reset_timeout_count", timeout_count, 0);
    rq_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // single read from requester 0, cache answers 3 cycles after the request appears
    rq_valid = 2'b01;
    #1;
    chk("read_rq_ready", rq_ready, 2'b01);
    step();
    rq_valid = '0;
    rq_addr[31:0] = 32'hBAD0_0BAD;
    chk("read_req_valid", cache_req_valid, 1);
    chk("read_req_addr", cache_req_addr, 32'h100);
    chk("read_req_wdata", cache_req_wdata, 32'h11);
    chk("read_req_wstrb", cache_req_wstrb, 4'hF);
    chk("read_busy_ready", rq_ready, 0);
    step();
    chk("read_addr_stable1", cache_req_addr, 32'h100);
    step();
    chk("read_addr_stable2", cache_req_addr, 32'h100);
    chk("read_valid_stable", cache_req_valid, 1);
    cache_resp_valid = 1'b1;
    cache_resp_rdata = 32'hDEADBEEF;
    #1;
    chk("read_rs_before", rs_valid, 0);
    step();
    cache_resp_valid = 1'b0;
    rq_addr[31:0] = 32'h100;
    chk("read_rs_valid", rs_valid, 2'b01);
    chk("read_rs_rdata", rs_rdata, 32'hDEADBEEF);
    chk("read_rs_err", rs_err, 0);
    chk("read_req_drop", cache_req_valid, 0);
    step();
    chk("read_rs_pulse", rs_valid, 0);

    // stall blocks acceptance for 5 cycles
    cache_resp_stall = 1'b1;
    rq_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rq_ready", rq_ready, 0);
      step();
      chk("stall_no_busy", cache_req_valid, 0);
    end
    cache_resp_stall = 1'b0;
    #1;
    chk("stall_release_ready", rq_ready, 2'b10);
    step();
    rq_valid = '0;
    chk("stall_req_valid", cache_req_valid, 1);
    chk("stall_req_addr", cache_req_addr, 32'h200);
    cache_resp_valid = 1'b1;
    cache_resp_rdata = 32'h1234_5678;
    step();
    cache_resp_valid = 1'b0;
    chk("stall_rs_valid", rs_valid, 2'b10);
    chk("stall_rs_rdata", rs_rdata, 32'h1234_5678);

    // spurious response in IDLE
    cache_resp_valid = 1'b1;
    cache_resp_rdata = 32'h5555_5555;
    step();
    chk("spur_rs_valid", rs_valid, 0);
    chk("spur_rs_rdata", rs_rdata, 32'h1234_5678);
    step();
    cache_resp_valid = 1'b0;
    chk("spur_rs_valid2", rs_valid, 0);
    chk("spur_idle", cache_req_valid, 0);

    // timeout: response exactly 8 cycles after cache_req_valid rises
    rq_valid = 2'b01;
    step();
    rq_valid = '0;
    chk("to_req_valid", cache_req_valid, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_rs_early", rs_valid, 0);
    end
    step();
    chk("to_rs_valid", rs_valid, 2'b01);
    chk("to_rs_err", rs_err, 1);
    chk("to_rs_rdata", rs_rdata, 0);
    chk("to_count", timeout_count, 1);
    chk("to_req_drop", cache_req_valid, 0);
    step();
    chk("to_rs_pulse", rs_valid, 0);

    // response on the timeout cycle wins
    rq_valid = 2'b01;
    step();
    rq_valid = '0;
    for (int i = 0; i < 7; i++) step();
    chk("coin_still_busy", cache_req_valid, 1);
    cache_resp_valid = 1'b1;
    cache_resp_rdata = 32'h0000_CAFE;
    step();
    cache_resp_valid = 1'b0;
    chk("coin_rs_valid", rs_valid, 2'b01);
    chk("coin_rs_err", rs_err, 0);
    chk("coin_rs_rdata", rs_rdata, 32'h0000_CAFE);
    chk("coin_count", timeout_count, 1);

    // reset mid-BUSY
    rq_valid = 2'b10;
    step();
    rq_valid = '0;
    step();
    chk("rst_busy", cache_req_valid, 1);
    #2;
    rst_n = 1'b0;
    rq_valid = 2'b11;
    #1;
    chk("rst_req_drop", cache_req_valid, 0);
    chk("rst_rq_ready", rq_ready, 0);
    chk("rst_count", timeout_count, 0);
    step();
    chk("rst_no_rs", rs_valid, 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_ptr_zero", rq_ready, 2'b01);
    chk("rst_no_rs2", rs_valid, 0);

    // fairness from reset: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("fair_rq_ready", rq_ready, exp_g);
      step();
      chk("fair_req_addr", cache_req_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      cache_resp_valid = 1'b1;
      cache_resp_rdata = 32'hA0 + i;
      step();
      cache_resp_valid = 1'b0;
      chk("fair_rs_valid", rs_valid, exp_g);
      chk("fair_rs_rdata", rs_rdata, 32'hA0 + i);
    end
    rq_valid = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/l1_req_arbiter.md
# l1_req_arbiter

Round-robin arbiter that shares the L1 cache's single CPU-side request/response port between `NUM_REQ` requesters, for example instruction fetch and load/store. It sits between the requesters and the cache core's `req_*`/`resp_*` interface. It allows one transaction in flight at a time: it holds the request stable until the cache responds, then routes the response back to the owning requester. A watchdog aborts transactions the cache never answers.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `TIMEOUT_CYCLES`, default 1024: maximum number of cycles in BUSY before abort. A value of 0 disables the timeout.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rq_valid`  in  NUM_REQ: per-requester request valid.
- `rq_ready`  out  NUM_REQ: one-hot accept. The handshake completes when `rq_valid[i] & rq_ready[i]`.
- `rq_we`  in  NUM_REQ: write enable, one bit per requester.
- `rq_addr`  in  NUM_REQ*32: addresses; requester i occupies bits [32i+31:32i].
- `rq_wdata`  in  NUM_REQ*32: write data, packed the same way.
- `rq_wstrb`  in  NUM_REQ*4: byte strobes; requester i occupies bits [4i+3:4i].
- `rs_valid`  out  NUM_REQ: one-cycle response pulse to the owning requester.
- `rs_rdata`  out  32: registered read data, shared by all requesters.
- `rs_err`  out  1: qualifies `rs_valid`; 1 means the transaction timed out.
- `cache_req_valid`, `cache_req_we`  out  1 each: to the cache.
- `cache_req_addr`, `cache_req_wdata`  out  32 each: to the cache.
- `cache_req_wstrb`  out  4: to the cache.
- `cache_resp_valid`  in  1: from the cache.
- `cache_resp_rdata`  in  32: from the cache.
- `cache_resp_stall`  in  1: from the cache.
- `timeout_count`  out  32: saturating count of aborted transactions.

## Operation
The arbiter has two states, IDLE and BUSY.

IDLE:
- If `cache_resp_stall`=0 and any `rq_valid` is high, select the winner by round-robin. Search starts at pointer `rr_ptr` and proceeds upward with wrap.
- Drive `rq_ready` one-hot to the winner. `rq_ready` is combinational and nonzero only in IDLE with stall=0.
- On the handshake:
  - latch the winner's `we`/`addr`/`wdata`/`wstrb` and its index `gnt`;
  - set `rr_ptr` to `(gnt+1) mod NUM_REQ`;
  - clear the timeout counter;
  - go to BUSY.
- If `cache_resp_stall`=1, `rq_ready`=0 and no request is accepted.

BUSY:
- `cache_req_valid`=1 with the latched payload, stable every cycle until exit.
- The timeout counter increments each cycle.
- If `cache_resp_valid`=1:
  - register `rs_rdata` from `cache_resp_rdata`, with `rs_err`=0;
  - pulse `rs_valid[gnt]` in the next cycle;
  - go to IDLE.
- Else, if `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`-1:
  - set `rs_rdata`=0 and `rs_err`=1;
  - pulse `rs_valid[gnt]`;
  - increment `timeout_count`, saturating at 0xFFFF_FFFF;
  - go to IDLE.
- A response and a timeout in the same cycle resolve as a response; the timeout does not apply.

Other rules:
- `cache_resp_valid` received in IDLE is spurious and is ignored.
- The outputs are identical for writes and reads. Write responses return whatever `cache_resp_rdata` carries.
- Requesters must hold `rq_valid` and payload stable until `rq_ready`; the arbiter does not check this.
- The timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Timing
Reset values (asynchronous):
- state=IDLE, `rr_ptr`=0;
- all `cache_req_*` outputs 0;
- `rs_valid`=0, `rs_rdata`=0, `rs_err`=0;
- `timeout_count`=0, timeout counter 0;
- `rq_ready`=0 for the duration of reset.

Latency:
- Handshake in cycle T gives `cache_req_valid` from cycle T+1.
- `cache_resp_valid` in cycle K gives `rs_valid` in cycle K+1 (registered). The arbiter is in IDLE in K+1, so the next handshake can occur in K+1.
- Minimum round trip is therefore 2 cycles plus cache latency. The arbiter adds 1 idle cycle of cache-port occupancy between transactions.

Reset mid-BUSY: the in-flight transaction is dropped, no `rs_valid` is issued, and `cache_req_valid` drops immediately.

`rs_valid` is always one-hot or zero.

## Structure
- Package `l1_arb_pkg` holds:
  - the `arb_state_e` enum {IDLE, BUSY};
  - `ADDR_W`=32, `DATA_W`=32, `STRB_W`=4;
  - the `cache_req_t` struct {`we`, `addr`, `wdata`, `wstrb`}.
- Sub-module `rr_pick` is combinational. Inputs: `req` vector and `rr_ptr`. Outputs: one-hot `gnt` and its binary index.
- The top-level block holds the FSM, payload register, timeout counter, and response register.

## Test plan
- Single read: requester 0 sends addr 0x100; cache responds with 0xDEADBEEF 3 cycles later. Expect `rs_valid[0]` one cycle after the cache response, `rs_rdata`=0xDEADBEEF, `rs_err`=0, and the cache payload stable throughout BUSY.
- Fairness: requesters 0 and 1 request continuously with `NUM_REQ`=2. Expect grants alternating 0,1,0,1 starting from 0 after reset.
- Stall: `cache_resp_stall`=1 for 5 cycles while `rq_valid[1]`=1. Expect `rq_ready`=0 for those cycles, and acceptance in the first cycle stall=0.
- Timeout: `TIMEOUT_CYCLES`=8 and the cache never responds. Expect `rs_valid` with `rs_err`=1 and `rs_rdata`=0 exactly 8 cycles after `cache_req_valid` rises, and `timeout_count`=1.
- Spurious and coincident events:
  - `cache_resp_valid` in IDLE: expect no `rs_valid`.
  - Response arriving on the timeout cycle: expect `rs_err`=0 and `timeout_count` unchanged.
- Reset mid-BUSY: assert `rst_n`=0 asynchronously. Expect `cache_req_valid`=0 immediately, no response issued, and `rr_ptr`=0 after release.
